// File: rtl/path_pulse_filter.sv
// rtl/path_pulse_filter.sv - one module path: rise/fall delay, pulse reject/error limits, pulse style, cancel handling
// Pending output transitions live in a small queue kept in maturity order; only the head can fire.
module path_pulse_filter #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_sig,
  input  logic [W-1:0]                 rise_dly,
  input  logic [W-1:0]                 fall_dly,
  input  logic [W-1:0]                 reject_lim,
  input  logic [W-1:0]                 error_lim,
  input  logic                         ondetect,
  input  logic                         showcancel,
  output logic                         out_sig,
  output logic                         out_x,
  output logic                         rej_stb,
  output logic                         err_stb,
  output logic                         cancel_stb,
  output logic                         ovf,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  rem_q [DEPTH];
  logic          val_q [DEPTH];
  logic          xv_q  [DEPTH];
  logic          in_last;
  logic [W-1:0]  w_q;

  logic [W-1:0]  age   [DEPTH];
  logic [W-1:0]  rem_n [DEPTH];
  logic          val_n [DEPTH];
  logic          xv_n  [DEPTH];
  logic [CW-1:0] cnt_n;
  logic [CW-1:0] tail;
  logic [W-1:0]  dly;
  logic [W-1:0]  tail_rem;
  logic          sig_n, x_n, rej_n, err_n, cancel_n, ovf_n;
  logic          edge_det, pop, push;

  always_comb begin
    edge_det = (in_sig != in_last);
    pop      = (q_count != '0) && (rem_q[0] <= W'(1));
    dly      = in_sig ? rise_dly : fall_dly;
    if (dly == '0) dly = W'(1);
    sig_n    = out_sig;
    x_n      = out_x;
    rej_n    = 1'b0;
    err_n    = 1'b0;
    cancel_n = 1'b0;
    ovf_n    = ovf;
    push     = 1'b0;
    tail     = '0;
    tail_rem = '0;
    cnt_n    = q_count;

    // Age every slot (saturating), then shift down by one if the head fires.
    for (int i = 0; i < DEPTH; i++) begin
      age[i] = (rem_q[i] != '0) ? rem_q[i] - W'(1) : '0;
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      rem_n[i] = pop ? age[i+1]   : age[i];
      val_n[i] = pop ? val_q[i+1] : val_q[i];
      xv_n[i]  = pop ? xv_q[i+1]  : xv_q[i];
    end
    rem_n[DEPTH-1] = pop ? '0   : age[DEPTH-1];
    val_n[DEPTH-1] = pop ? 1'b0 : val_q[DEPTH-1];
    xv_n[DEPTH-1]  = pop ? 1'b0 : xv_q[DEPTH-1];

    if (pop) begin
      if (xv_q[0]) begin
        x_n = 1'b1;
      end else begin
        sig_n = val_q[0];
        x_n   = 1'b0;
      end
      cnt_n = q_count - CW'(1);
    end

    if (edge_det) begin
      push = 1'b1;
      if (cnt_n != '0) begin
        tail = cnt_n - CW'(1);
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == tail) tail_rem = rem_n[i];
        end
        if (w_q < reject_lim) begin
          rej_n = 1'b1;
          push  = 1'b0;
          cnt_n = tail;
        end else if (w_q < error_lim) begin
          err_n = 1'b1;
          if (ondetect) begin
            cnt_n = tail;
            x_n   = 1'b1;
          end else begin
            for (int i = 0; i < DEPTH; i++) begin
              if (CW'(i) == tail) xv_n[i] = 1'b1;
            end
          end
        end else if (dly <= tail_rem) begin
          cancel_n = 1'b1;
          cnt_n    = tail;
          if (showcancel) x_n = 1'b1;
        end
      end
      if (push) begin
        if (cnt_n == CW'(DEPTH)) begin
          ovf_n = 1'b1;
          x_n   = 1'b1;
          cnt_n = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == cnt_n) begin
            rem_n[i] = dly;
            val_n[i] = in_sig;
            xv_n[i]  = 1'b0;
          end
        end
        cnt_n = cnt_n + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sig    <= 1'b0;
      out_x      <= 1'b0;
      rej_stb    <= 1'b0;
      err_stb    <= 1'b0;
      cancel_stb <= 1'b0;
      ovf        <= 1'b0;
      q_count    <= '0;
      in_last    <= 1'b0;
      w_q        <= '1;
      for (int i = 0; i < DEPTH; i++) begin
        rem_q[i] <= '0;
        val_q[i] <= 1'b0;
        xv_q[i]  <= 1'b0;
      end
    end else begin
      out_sig    <= sig_n;
      out_x      <= x_n;
      rej_stb    <= rej_n;
      err_stb    <= err_n;
      cancel_stb <= cancel_n;
      ovf        <= ovf_n;
      q_count    <= cnt_n;
      in_last    <= in_sig;
      // Width since the previous edge, held at all-ones once saturated.
      if (edge_det)        w_q <= W'(1);
      else if (w_q != '1)  w_q <= w_q + W'(1);
      for (int i = 0; i < DEPTH; i++) begin
        rem_q[i] <= rem_n[i];
        val_q[i] <= val_n[i];
        xv_q[i]  <= xv_n[i];
      end
    end
  end
endmodule
